// File: rtl/motoro3_gate_deadtime.sv
// Three-phase gate driver with per-phase dead-time FSMs and a latched overcurrent shutdown.
// Optional MOTORO3_COMP_PWM_EN: complementary chopping of the driven-high phase's low side.
module motoro3_gate_deadtime #(
    parameter int DEAD_CYC = 20,
    parameter int DT_W     = 8
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       aE,
    input  logic       aH1_L0,
    input  logic       bE,
    input  logic       bH1_L0,
    input  logic       cE,
    input  logic       cH1_L0,
    input  logic       pwm,
    input  logic       enable,
    input  logic       fault_n,
    input  logic       fault_clr,
    output logic       aHS,
    output logic       aLS,
    output logic       bHS,
    output logic       bLS,
    output logic       cHS,
    output logic       cLS,
    output logic       fault_latched,
    output logic [2:0] dead_active
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HS_ON = 2'd1,
        ST_LS_ON = 2'd2,
        ST_DEAD  = 2'd3
    } phase_state_t;

    localparam logic [DT_W-1:0] DEAD_LOAD = DT_W'(DEAD_CYC - 1);
    localparam logic [DT_W-1:0] CNT_ONE   = DT_W'(1);
    localparam logic [DT_W-1:0] CNT_ZERO  = DT_W'(0);

    logic       r_fault_s1;
    logic       r_fault_s2;
    logic       r_fault_latched;
    logic       w_kill;
    logic [2:0] w_e;
    logic [2:0] w_h;
    logic [2:0] w_want_hs;
    logic [2:0] w_want_ls;
    logic [2:0] w_hs;
    logic [2:0] w_ls;
    logic [2:0] w_dead;

    assign w_e = {cE, bE, aE};
    assign w_h = {cH1_L0, bH1_L0, aH1_L0};

    // Two-flop synchroniser for the asynchronous comparator output
    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            r_fault_s1 <= 1'b1;
            r_fault_s2 <= 1'b1;
        end else begin
            r_fault_s1 <= fault_n;
            r_fault_s2 <= r_fault_s1;
        end
    end

    // Fault latch: a synchronised low always wins over a clear request
    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            r_fault_latched <= 1'b0;
        end else if (!r_fault_s2) begin
            r_fault_latched <= 1'b1;
        end else if (fault_clr) begin
            r_fault_latched <= 1'b0;
        end else begin
            r_fault_latched <= r_fault_latched;
        end
    end

    assign w_kill = r_fault_latched | ~enable | ~r_fault_s2;

    for (genvar g = 0; g < 3; g++) begin : g_phase
        phase_state_t    r_state;
        phase_state_t    w_state_nxt;
        logic [DT_W-1:0] r_cnt;
        logic [DT_W-1:0] w_cnt_nxt;
        logic            r_hs;
        logic            r_ls;
        logic            r_dead;

        assign w_want_hs[g] = w_e[g] & w_h[g] & pwm & ~w_kill;
`ifdef MOTORO3_COMP_PWM_EN
        assign w_want_ls[g] = w_e[g] & (~w_h[g] | ~pwm) & ~w_kill;
`else
        assign w_want_ls[g] = w_e[g] & ~w_h[g] & ~w_kill;
`endif

        // Next state: every turn-off passes through DEAD, which runs to completion
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            case (r_state)
                ST_IDLE: begin
                    if (w_want_hs[g]) begin
                        w_state_nxt = ST_HS_ON;
                    end else if (w_want_ls[g]) begin
                        w_state_nxt = ST_LS_ON;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_HS_ON: begin
                    if (!w_want_hs[g]) begin
                        w_state_nxt = ST_DEAD;
                        w_cnt_nxt   = DEAD_LOAD;
                    end else begin
                        w_state_nxt = ST_HS_ON;
                    end
                end
                ST_LS_ON: begin
                    if (!w_want_ls[g]) begin
                        w_state_nxt = ST_DEAD;
                        w_cnt_nxt   = DEAD_LOAD;
                    end else begin
                        w_state_nxt = ST_LS_ON;
                    end
                end
                ST_DEAD: begin
                    if (r_cnt != CNT_ZERO) begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end else if (w_want_hs[g]) begin
                        w_state_nxt = ST_HS_ON;
                    end else if (w_want_ls[g]) begin
                        w_state_nxt = ST_LS_ON;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end
            endcase
        end

        // State, counter and gate flops; gates decode the next state so they track it exactly
        always_ff @(negedge clk or negedge nRst) begin
            if (!nRst) begin
                r_state <= ST_IDLE;
                r_cnt   <= CNT_ZERO;
                r_hs    <= 1'b0;
                r_ls    <= 1'b0;
                r_dead  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_hs    <= (w_state_nxt == ST_HS_ON);
                r_ls    <= (w_state_nxt == ST_LS_ON);
                r_dead  <= (w_state_nxt == ST_DEAD);
            end
        end

        assign w_hs[g]   = r_hs;
        assign w_ls[g]   = r_ls;
        assign w_dead[g] = r_dead;
    end

    assign aHS           = w_hs[0];
    assign aLS           = w_ls[0];
    assign bHS           = w_hs[1];
    assign bLS           = w_ls[1];
    assign cHS           = w_hs[2];
    assign cLS           = w_ls[2];
    assign dead_active   = w_dead;
    assign fault_latched = r_fault_latched;

endmodule

// File: tb/tb_motoro3_gate_deadtime.sv
// Randomised + directed bench for motoro3_gate_deadtime (DEAD_CYC=4) against a timestamp-based model.
module tb_motoro3_gate_deadtime;

    localparam int DC = 4;

    logic clk = 1'b0;
    logic nRst, aE, aH1_L0, bE, bH1_L0, cE, cH1_L0, pwm, enable, fault_n, fault_clr;
    logic aHS, aLS, bHS, bLS, cHS, cLS, fault_latched;
    logic [2:0] dead_active;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    motoro3_gate_deadtime #(.DEAD_CYC(DC), .DT_W(8)) dut (
        .clk(clk), .nRst(nRst),
        .aE(aE), .aH1_L0(aH1_L0), .bE(bE), .bH1_L0(bH1_L0), .cE(cE), .cH1_L0(cH1_L0),
        .pwm(pwm), .enable(enable), .fault_n(fault_n), .fault_clr(fault_clr),
        .aHS(aHS), .aLS(aLS), .bHS(bHS), .bLS(bLS), .cHS(cHS), .cLS(cLS),
        .fault_latched(fault_latched), .dead_active(dead_active)
    );

    always #50 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: side currently conducting and the edge index at which the gap ends
    int n_edge;
    int on_side [3];
    int dead_end [3];
    bit fq [$];
    bit m_latched;

    function automatic bit m_want_hs(input bit e, input bit h, input bit p, input bit k);
        return e && h && p && !k;
    endfunction

    function automatic bit m_want_ls(input bit e, input bit h, input bit p, input bit k);
`ifdef MOTORO3_COMP_PWM_EN
        return e && (!h || !p) && !k;
`else
        return e && !h && !k;
`endif
    endfunction

    always @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            n_edge = 0;
            m_latched = 1'b0;
            fq = {1'b1, 1'b1};
            for (int p = 0; p < 3; p++) begin
                on_side[p] = 0;
                dead_end[p] = 0;
            end
        end else begin
            bit sync, kill, wh, wl;
            bit [2:0] e, h;
            n_edge++;
            sync = fq[0];
            void'(fq.pop_front());
            fq.push_back(fault_n);
            kill = m_latched || !enable || !sync;
            e = {cE, bE, aE};
            h = {cH1_L0, bH1_L0, aH1_L0};
            for (int p = 0; p < 3; p++) begin
                wh = m_want_hs(e[p], h[p], pwm, kill);
                wl = m_want_ls(e[p], h[p], pwm, kill);
                if ((on_side[p] == 1 && !wh) || (on_side[p] == 2 && !wl)) begin
                    on_side[p] = 0;
                    dead_end[p] = n_edge + DC;
                end else if (on_side[p] == 0 && n_edge >= dead_end[p]) begin
                    on_side[p] = wh ? 1 : (wl ? 2 : 0);
                end
            end
            if (!sync) m_latched = 1'b1;
            else if (fault_clr) m_latched = 1'b0;
        end
    end

    // Compare process: outputs are stable away from the falling (active) edge
    always @(posedge clk) begin
        if (chk_en) begin
            logic [2:0] hs, ls;
            logic [2:0] exp_hs, exp_ls, exp_dead;
            hs = {cHS, bHS, aHS};
            ls = {cLS, bLS, aLS};
            for (int p = 0; p < 3; p++) begin
                exp_hs[p] = (on_side[p] == 1);
                exp_ls[p] = (on_side[p] == 2);
                exp_dead[p] = (on_side[p] == 0) && (n_edge < dead_end[p]);
            end
            check("model_hs", hs, exp_hs);
            check("model_ls", ls, exp_ls);
            check("model_dead", dead_active, exp_dead);
            check("model_fault_latched", fault_latched, m_latched);
            check("no_shoot_through", hs & ls, 3'b000);
        end
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ph(input logic [2:0] e, input logic [2:0] h);
        {cE, bE, aE} = e;
        {cH1_L0, bH1_L0, aH1_L0} = h;
    endtask

    int hs_ph [6] = '{0, 0, 1, 1, 2, 2};
    int ls_ph [6] = '{1, 2, 2, 0, 0, 1};
    int ls_cnt;

    initial begin
        logic [2:0] e, h;
        nRst = 1'b0; pwm = 1'b0; enable = 1'b0; fault_n = 1'b1; fault_clr = 1'b0;
        set_ph(3'b000, 3'b000);
        cyc(3);
        nRst = 1'b1;
        chk_en = 1'b1;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            check("reset_idle", {aHS, aLS, bHS, bLS, cHS, cLS, fault_latched, dead_active}, 10'd0);
        end

        // Turn-on latency and HS->LS handover
        enable = 1'b1; pwm = 1'b1; set_ph(3'b001, 3'b001);
        cyc(1);
        check("a_hs_on", aHS, 1'b1);
        aH1_L0 = 1'b0;
        for (int i = 0; i < DC; i++) begin
            cyc(1);
            check("handover_dead", {aHS, aLS, dead_active}, {2'b00, 3'b001});
        end
        cyc(1);
        check("handover_ls_on", {aHS, aLS, dead_active}, {2'b01, 3'b000});

        // One-cycle request drop still costs a full dead time
        aH1_L0 = 1'b1;
        cyc(DC + 2);
        check("hs_restored", aHS, 1'b1);
        aH1_L0 = 1'b0;
        cyc(1);
        aH1_L0 = 1'b1;
        for (int i = 0; i < DC - 1; i++) begin
            cyc(1);
            check("blip_gap", {aHS, aLS}, 2'b00);
        end
        cyc(1);
        check("blip_hs_back", aHS, 1'b1);

        // Overcurrent shutdown and clear
        set_ph(3'b011, 3'b001);
        cyc(10);
        check("pre_fault_on", {aHS, bLS}, 2'b11);
        fault_n = 1'b0;
        cyc(1);
        fault_n = 1'b1;
        cyc(2);
        check("fault_kill", {aHS, aLS, bHS, bLS, cHS, cLS, fault_latched}, 7'b0000001);
        cyc(10);
        check("fault_still_latched", {fault_latched, aHS}, 2'b10);
        fault_clr = 1'b1;
        cyc(1);
        fault_clr = 1'b0;
        check("fault_cleared", fault_latched, 1'b0);
        cyc(1);
        check("resume_after_clear", {aHS, bLS}, 2'b11);

        // Async reset while in DEAD
        aE = 1'b0;
        cyc(2);
        check("pre_reset_dead", dead_active[0], 1'b1);
        nRst = 1'b0;
        #1;
        check("async_reset_mid_dead", {aHS, aLS, dead_active}, 5'd0);
        cyc(2);
        nRst = 1'b1;

        // Chopping of a driven-high phase: low side only in complementary mode
        set_ph(3'b001, 3'b001); pwm = 1'b1;
        cyc(10);
        ls_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            if (i % 20 == 0) pwm = ((i / 20) % 2 == 0);
            cyc(1);
            if (aLS) ls_cnt++;
        end
`ifdef MOTORO3_COMP_PWM_EN
        check("comp_pwm_ls_cycles", ls_cnt, 32'd32);
`else
        check("no_comp_ls_cycles", ls_cnt, 32'd0);
`endif

        // Six-step commutation with 50% pwm, period 40
        for (int s = 0; s < 6; s++) begin
            e = 3'b000; h = 3'b000;
            e[hs_ph[s]] = 1'b1; e[ls_ph[s]] = 1'b1; h[hs_ph[s]] = 1'b1;
            set_ph(e, h);
            for (int c = 0; c < 120; c++) begin
                pwm = ((c % 40) < 20);
                cyc(1);
            end
        end

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(7, 0) == 0) begin
                int p;
                p = $urandom_range(2, 0);
                e = {cE, bE, aE}; h = {cH1_L0, bH1_L0, aH1_L0};
                e[p] = $urandom_range(1, 0);
                h[p] = $urandom_range(1, 0);
                set_ph(e, h);
            end
            if ($urandom_range(9, 0) == 0) pwm = ~pwm;
            enable = ($urandom_range(199, 0) != 0);
            fault_n = ($urandom_range(399, 0) != 0);
            fault_clr = ($urandom_range(39, 0) == 0);
            cyc(1);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
